// File: rtl/goertzel_axil_regs.sv
// goertzel_axil_regs: AXI-lite register file for the Goertzel core; `define GOERTZEL_REGS_IRQ_EN adds IRQ_EN (0x1C) and irq_o
package axi_pkg;
  typedef struct packed {
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axi_lite_mosi;
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
  } axi_lite_miso;
endpackage

module goertzel_axil_regs #(
  parameter int          COEFF_W = 18,
  parameter int          N_W     = 16,
  parameter int          N_DEF   = 205,
  parameter int          RES_W   = 48,
  parameter logic [31:0] ID_VAL  = 32'h4745_0001
) (
  input  logic                  axi_clk_i,
  input  logic                  axi_rstn_i,
  input  axi_pkg::axi_lite_mosi axii_i,
  output axi_pkg::axi_lite_miso axio_o,
  output logic                  enable_o,
  output logic                  start_o,
  output logic [COEFF_W-1:0]    coeff_o,
  output logic [N_W-1:0]        nsamp_o,
  input  logic                  core_busy_i,
  input  logic                  core_done_i,
  input  logic [RES_W-1:0]      result_i
`ifdef GOERTZEL_REGS_IRQ_EN
  ,
  output logic                  irq_o
`endif
);
  logic        up, aw_held, w_held, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, aw_addr, w_data, wmask, rd_val;
  logic [3:0]  w_strb;
  logic        done, start_err;
  logic [RES_W-1:0] res_q;
  logic [63:0] res_ext;
  logic        awready, wready, arready, aw_hs, w_hs, ar_hs;
  logic        wr_fire, wr_bad, rd_bad, ctrl_wr, w1c, start_ok;
  logic [2:0]  widx;
  logic        unused;
`ifdef GOERTZEL_REGS_IRQ_EN
  logic [1:0]  irq_en;
`endif

  function automatic logic [31:0] merge(input logic [31:0] old, d, m);
    return (old & ~m) | (d & m);
  endfunction

  // up holds all ready signals low during reset and the first cycle after it
  assign awready  = up & ~aw_held & ~bvalid;
  assign wready   = up & ~w_held & ~bvalid;
  assign arready  = up & ~rvalid;
  assign aw_hs    = axii_i.awvalid & awready;
  assign w_hs     = axii_i.wvalid & wready;
  assign ar_hs    = axii_i.arvalid & arready;
  assign wr_fire  = aw_held & w_held & ~bvalid;
  assign wr_bad   = |aw_addr[31:5];
  assign rd_bad   = |axii_i.araddr[31:5];
  assign widx     = aw_addr[4:2];
  assign wmask    = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign ctrl_wr  = wr_fire & ~wr_bad & (widx == 3'd0) & w_strb[0];
  assign w1c      = wr_fire & ~wr_bad & (widx == 3'd1) & w_strb[0];
  assign start_ok = w_data[0] & ~core_busy_i;
  assign res_ext  = 64'(res_q);
  assign unused   = ^{axii_i.awprot, axii_i.arprot, axii_i.araddr[1:0], aw_addr[1:0]};
  assign axio_o   = '{awready: awready, wready: wready, bresp: bresp, bvalid: bvalid,
                      arready: arready, rdata: rdata, rresp: rresp, rvalid: rvalid};

  // Read mux; STATUS/RESULT reflect register state before any same-cycle update
  always_comb begin
    rd_val = '0;
    case (axii_i.araddr[4:2])
      3'd0: rd_val = {31'd0, enable_o};
      3'd1: rd_val = {29'd0, start_err, done, core_busy_i};
      3'd2: rd_val = 32'(coeff_o);
      3'd3: rd_val = 32'(nsamp_o);
      3'd4: rd_val = res_ext[31:0];
      3'd5: rd_val = res_ext[63:32];
      3'd6: rd_val = ID_VAL;
`ifdef GOERTZEL_REGS_IRQ_EN
      default: rd_val = {30'd0, irq_en};
`else
      default: rd_val = '0;
`endif
    endcase
  end

  // Write path: AW/W holding, register update with B response, start pulse, sticky status
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      up        <= 1'b0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
      bvalid    <= 1'b0;
      bresp     <= '0;
      enable_o  <= 1'b0;
      start_o   <= 1'b0;
      coeff_o   <= '0;
      nsamp_o   <= N_W'(N_DEF);
      done      <= 1'b0;
      start_err <= 1'b0;
      res_q     <= '0;
    end else begin
      up <= 1'b1;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_addr <= axii_i.awaddr;
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= axii_i.wdata;
        w_strb <= axii_i.wstrb;
      end
      if (bvalid & axii_i.bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= wr_bad ? 2'b10 : 2'b00;
      end
      if (ctrl_wr) enable_o <= w_data[0];
      if (wr_fire & ~wr_bad & (widx == 3'd2))
        coeff_o <= COEFF_W'(merge(32'(coeff_o), w_data, wmask));
      if (wr_fire & ~wr_bad & (widx == 3'd3))
        nsamp_o <= N_W'(merge(32'(nsamp_o), w_data, wmask));
      start_o   <= ctrl_wr & w_data[1] & start_ok;
      start_err <= (start_err & ~(w1c & w_data[2])) | (ctrl_wr & w_data[1] & ~start_ok);
      done      <= (done & ~(w1c & w_data[1])) | core_done_i;
      if (core_done_i) res_q <= result_i;
    end
  end

  // Read path: register data/response on AR handshake, hold until rready
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= '0;
    end else begin
      if (rvalid & axii_i.rready) rvalid <= 1'b0;
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_bad ? '0 : rd_val;
        rresp  <= rd_bad ? 2'b10 : 2'b00;
      end
    end
  end

`ifdef GOERTZEL_REGS_IRQ_EN
  // IRQ enable register and registered interrupt from enabled sticky bits
  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      irq_en <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_fire & ~wr_bad & (widx == 3'd7) & w_strb[0]) irq_en <= w_data[1:0];
      irq_o <= |(irq_en & {start_err, done});
    end
  end
`endif
endmodule
